// File: rtl/modn_pkg.sv
// Shared constants and helpers for the cascaded modulo-N counter.
package modn_pkg;

  localparam int DEFAULT_MODULUS = 10;
  localparam int DEFAULT_DIGITS  = 4;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/modn_digit.sv
// One modulo-MODULUS digit: parallel load with clamping, single up/down step.
module modn_digit #(
  parameter int MODULUS = 10,
  parameter int DW      = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [DW-1:0] load_digit,
  input  logic          step,
  input  logic          up_dn,
  output logic [DW-1:0] digit,
  output logic          at_max,
  output logic          at_min
);

  localparam logic [DW-1:0] MAX_VAL = DW'(MODULUS - 1);

  // Out-of-range load values saturate to the largest legal digit.
  function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  assign at_max = (digit == MAX_VAL);
  assign at_min = (digit == '0);

  // Digit register: load wins over step; step wraps within 0..MODULUS-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_digit(load_digit);
    end else if (step) begin
      if (up_dn) digit <= at_max ? '0 : digit + 1'b1;
      else       digit <= at_min ? MAX_VAL : digit - 1'b1;
    end
  end

endmodule

// File: rtl/modn_counter_chain.sv
// Cascaded modulo-N up/down counter with load, saturate mode, tc and wrap pulse.
module modn_counter_chain
  import modn_pkg::*;
#(
  parameter int DIGITS   = DEFAULT_DIGITS,
  parameter int MODULUS  = DEFAULT_MODULUS,
  parameter int SATURATE = 0
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         en,
  input  logic                                         up_dn,
  input  logic                                         load,
  input  logic [DIGITS*modn_pkg::clog2_min1(MODULUS)-1:0] load_val,
  output logic [DIGITS*modn_pkg::clog2_min1(MODULUS)-1:0] count,
  output logic                                         tc,
  output logic                                         wrap
);

  localparam int DW  = clog2_min1(MODULUS);
  localparam bit SAT = (SATURATE != 0);

  // pre_max[i] / pre_min[i]: every digit below i sits at its extreme.
  logic [DIGITS:0]   pre_max;
  logic [DIGITS:0]   pre_min;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] step;
  logic              hold;

  assign pre_max[0] = 1'b1;
  assign pre_min[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign pre_max[i+1] = pre_max[i] & at_max[i];
    assign pre_min[i+1] = pre_min[i] & at_min[i];
    assign step[i]      = en & ~hold & (up_dn ? pre_max[i] : pre_min[i]);

    modn_digit #(
      .MODULUS (MODULUS),
      .DW      (DW)
    ) u_digit (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .load_digit (load_val[i*DW +: DW]),
      .step       (step[i]),
      .up_dn      (up_dn),
      .digit      (count[i*DW +: DW]),
      .at_max     (at_max[i]),
      .at_min     (at_min[i])
    );
  end

  // tc flags that the coming edge would cross the extreme in the current direction.
  assign tc   = en & (up_dn ? pre_max[DIGITS] : pre_min[DIGITS]);
  // In saturate mode the whole chain freezes at the extreme instead of wrapping.
  assign hold = SAT & tc;

  // Wrap pulse: one cycle after an enabled edge that rolled over the extreme.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wrap <= 1'b0;
    else          wrap <= ~load & tc & ~SAT;
  end

endmodule

// File: tb/tb_modn_counter_chain.sv
// Bench for modn_counter_chain: three configurations against an integer model.
module tb_modn_counter_chain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en_s [3];
  logic        ud_s [3];
  logic        ld_s [3];
  logic [11:0] lv_s [3];
  logic [7:0]  cnt0, cnt1;
  logic [8:0]  cnt2;
  logic        tc0, tc1, tc2;
  logic        wr0, wr1, wr2;

  int n_chk  = 0;
  int n_pass = 0;

  // Integer model state: counter value and wrap flag per configuration.
  int mn [3];
  bit mw [3];

  always #5 clk = ~clk;

  modn_counter_chain #(.DIGITS(2), .MODULUS(10), .SATURATE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .en(en_s[0]), .up_dn(ud_s[0]), .load(ld_s[0]),
    .load_val(lv_s[0][7:0]), .count(cnt0), .tc(tc0), .wrap(wr0));
  modn_counter_chain #(.DIGITS(2), .MODULUS(10), .SATURATE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .en(en_s[1]), .up_dn(ud_s[1]), .load(ld_s[1]),
    .load_val(lv_s[1][7:0]), .count(cnt1), .tc(tc1), .wrap(wr1));
  modn_counter_chain #(.DIGITS(3), .MODULUS(6), .SATURATE(0)) u2 (
    .clk(clk), .reset_n(reset_n), .en(en_s[2]), .up_dn(ud_s[2]), .load(ld_s[2]),
    .load_val(lv_s[2][8:0]), .count(cnt2), .tc(tc2), .wrap(wr2));

  function automatic int cfg_mod(input int k); return (k == 2) ? 6 : 10; endfunction
  function automatic int cfg_dig(input int k); return (k == 2) ? 3 : 2;  endfunction
  function automatic int cfg_dw (input int k); return (k == 2) ? 3 : 4;  endfunction
  function automatic bit cfg_sat(input int k); return (k == 1);          endfunction

  function automatic int total(input int k);
    int t = 1;
    for (int d = 0; d < cfg_dig(k); d++) t = t * cfg_mod(k);
    return t;
  endfunction

  function automatic logic [11:0] get_cnt(input int k);
    case (k)
      0:       return {4'b0, cnt0};
      1:       return {4'b0, cnt1};
      default: return {3'b0, cnt2};
    endcase
  endfunction

  function automatic bit get_tc(input int k);
    case (k)
      0:       return tc0;
      1:       return tc1;
      default: return tc2;
    endcase
  endfunction

  function automatic bit get_wrap(input int k);
    case (k)
      0:       return wr0;
      1:       return wr1;
      default: return wr2;
    endcase
  endfunction

  // Integer value -> packed digits, least significant digit in the LSBs.
  function automatic logic [11:0] pack(input int k, input int n);
    logic [11:0] r = '0;
    int v = n;
    for (int d = 0; d < cfg_dig(k); d++) begin
      r = r | (12'(v % cfg_mod(k)) << (d * cfg_dw(k)));
      v = v / cfg_mod(k);
    end
    return r;
  endfunction

  // Packed load value -> integer, each digit clamped to MODULUS-1.
  function automatic int unpack_clamped(input int k, input logic [11:0] lv);
    int n = 0;
    int dg;
    for (int d = cfg_dig(k) - 1; d >= 0; d--) begin
      dg = int'((lv >> (d * cfg_dw(k))) & ((12'd1 << cfg_dw(k)) - 12'd1));
      if (dg > cfg_mod(k) - 1) dg = cfg_mod(k) - 1;
      n = n * cfg_mod(k) + dg;
    end
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      mn[j] = 0;
      mw[j] = 1'b0;
    end
  endtask

  // Drive one configuration for one clock; others idle. Returns DUT tc and model tc seen before the edge.
  task automatic run_cycle(input int k, input bit ld, input logic [11:0] lv, input bit e,
                           input bit ud, output bit tc_dut, output bit tc_mdl);
    int t;
    for (int j = 0; j < 3; j++) begin
      en_s[j] = 1'b0;
      ld_s[j] = 1'b0;
    end
    en_s[k] = e;
    ld_s[k] = ld;
    ud_s[k] = ud;
    lv_s[k] = lv;
    #1;
    tc_dut = get_tc(k);
    t = total(k);
    tc_mdl = e & (ud ? (mn[k] == t - 1) : (mn[k] == 0));
    for (int j = 0; j < 3; j++) if (j != k) mw[j] = 1'b0;
    if (ld) begin
      mn[k] = unpack_clamped(k, lv);
      mw[k] = 1'b0;
    end else if (e) begin
      if (tc_mdl && cfg_sat(k)) begin
        mw[k] = 1'b0;
      end else begin
        mn[k] = ud ? (mn[k] + 1) % t : (mn[k] + t - 1) % t;
        mw[k] = tc_mdl;
      end
    end else begin
      mw[k] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          k;
    bit          ld;
    logic [11:0] lv;
    bit          e;
    bit          ud;
    logic [11:0] cnt;
    bit          tc;
    bit          wr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit tcd, tcm;
    int tc_hits, wr_hits, k;
    bit ld, e, ud;
    logic [11:0] lv;

    // k, load, load_val, en, up_dn, expected count, expected tc (pre-edge), expected wrap
    for (int i = 1; i <= 5; i++) tbl.push_back('{0, 0, 12'h000, 1, 1, 12'(i), 0, 0});
    tbl.push_back('{0, 1, 12'h098, 0, 1, 12'h098, 0, 0});
    tbl.push_back('{0, 0, 12'h000, 1, 1, 12'h099, 0, 0});
    tbl.push_back('{0, 0, 12'h000, 1, 1, 12'h000, 1, 1});
    tbl.push_back('{0, 0, 12'h000, 1, 1, 12'h001, 0, 0});
    tbl.push_back('{0, 1, 12'h010, 0, 0, 12'h010, 0, 0});
    tbl.push_back('{0, 0, 12'h000, 1, 0, 12'h009, 0, 0});
    tbl.push_back('{0, 1, 12'h000, 1, 0, 12'h000, 0, 0});
    tbl.push_back('{0, 0, 12'h000, 1, 0, 12'h099, 1, 1});
    tbl.push_back('{0, 0, 12'h000, 1, 0, 12'h098, 0, 0});
    tbl.push_back('{0, 1, 12'h0C3, 1, 1, 12'h093, 0, 0});
    tbl.push_back('{0, 0, 12'h000, 1, 1, 12'h094, 0, 0});
    tbl.push_back('{0, 0, 12'h000, 0, 1, 12'h094, 0, 0});
    tbl.push_back('{1, 1, 12'h098, 0, 1, 12'h098, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 1, 12'h099, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 1, 12'h099, 1, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 1, 12'h099, 1, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 0, 12'h098, 0, 0});
    tbl.push_back('{1, 1, 12'h000, 0, 0, 12'h000, 0, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 0, 12'h000, 1, 0});
    tbl.push_back('{1, 0, 12'h000, 1, 1, 12'h001, 0, 0});

    reset_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      en_s[j] = 1'b0;
      ud_s[j] = 1'b1;
      ld_s[j] = 1'b0;
      lv_s[j] = '0;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("reset_count%0d", j), 32'(get_cnt(j)), 32'h0);
      check($sformatf("reset_wrap%0d", j), 32'(get_wrap(j)), 32'h0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      if (i == 5) begin
        // Reset asserted between edges must clear count immediately.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_count", 32'(get_cnt(0)), 32'h0);
        check("async_reset_wrap", 32'(get_wrap(0)), 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      run_cycle(tbl[i].k, tbl[i].ld, tbl[i].lv, tbl[i].e, tbl[i].ud, tcd, tcm);
      check($sformatf("vec%0d_tc", i), 32'(tcd), 32'(tbl[i].tc));
      check($sformatf("vec%0d_count", i), 32'(get_cnt(tbl[i].k)), 32'(tbl[i].cnt));
      check($sformatf("vec%0d_wrap", i), 32'(get_wrap(tbl[i].k)), 32'(tbl[i].wr));
    end

    // MODULUS=6, DIGITS=3: a full 216-step revolution from zero.
    check("m6_start", 32'(get_cnt(2)), 32'h0);
    tc_hits = 0;
    wr_hits = 0;
    for (int c = 0; c < 216; c++) begin
      run_cycle(2, 1'b0, 12'h0, 1'b1, 1'b1, tcd, tcm);
      if (tcd) tc_hits++;
      if (get_wrap(2)) wr_hits++;
      check($sformatf("m6_count_%0d", c), 32'(get_cnt(2)), 32'(pack(2, mn[2])));
    end
    check("m6_end_count", 32'(get_cnt(2)), 32'h0);
    check("m6_tc_hits", 32'(tc_hits), 32'd1);
    check("m6_wrap_hits", 32'(wr_hits), 32'd1);
    run_cycle(2, 1'b0, 12'h0, 1'b1, 1'b1, tcd, tcm);
    check("m6_wrap_one_cycle", 32'(get_wrap(2)), 32'h0);

    // Randomised traffic on all three configurations.
    for (int c = 0; c < 450; c++) begin
      k  = $urandom_range(0, 2);
      ld = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 4) != 0);
      ud = $urandom_range(0, 1) != 0;
      lv = 12'($urandom);
      run_cycle(k, ld, lv, e, ud, tcd, tcm);
      check($sformatf("rnd%0d_tc_k%0d", c, k), 32'(tcd), 32'(tcm));
      check($sformatf("rnd%0d_count_k%0d", c, k), 32'(get_cnt(k)), 32'(pack(k, mn[k])));
      check($sformatf("rnd%0d_wrap_k%0d", c, k), 32'(get_wrap(k)), 32'(mw[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/modn_counter_chain.md
Name: modn_counter_chain

Overview:
- Parametrised cascaded modulo-N up/down counter: DIGITS digit stages, each counting 0..MODULUS-1, chained by ripple-free carry/borrow lookahead.
- Generalises the single mod-10 digit with enable, direction, parallel load, saturate mode, terminal-count and wrap outputs.
- Used as a timebase, BCD event counter or display-digit source feeding decode/display logic in lab designs.

Parameters:
- DIGITS, 4, number of cascaded digit stages; legal range 1..8.
- MODULUS, 10, per-digit modulus; legal range 2..16.
- DW, $clog2(MODULUS), bits per digit. Derived localparam, not overridable.
- SATURATE, 0, selects the extreme behaviour: 0 wraps at the extremes, 1 holds at the extremes.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- en, input, 1, count enable for the cycle.
- up_dn, input, 1, direction: 1 counts up, 0 counts down.
- load, input, 1, synchronous parallel load.
- load_val, input, DIGITS*DW, load value; digit 0 occupies the LSBs.
- count, output, DIGITS*DW, registered count; digit 0 occupies the LSBs.
- tc, output, 1, combinational terminal count.
- wrap, output, 1, registered one-cycle pulse.

Behaviour:
- Reset:
  - reset_n low immediately forces count to 0 and wrap to 0.
  - Reset asserted mid-count takes effect immediately, without waiting for a clock edge.
  - The first count or load takes effect on the first rising edge after reset_n goes high.
- Priority per rising edge: load > en > hold.
- Load:
  - count <= load_val, digit by digit.
  - Any digit value >= MODULUS is clamped to MODULUS-1.
  - wrap <= 0 on a load cycle.
  - en is ignored when load is high.
- Up count (en=1, up_dn=1):
  - Digit 0 increments.
  - Digit i>0 increments only when digits 0..i-1 all equal MODULUS-1.
  - A digit equal to MODULUS-1 that increments becomes 0.
- Down count (en=1, up_dn=0):
  - Digit 0 decrements.
  - Digit i>0 decrements only when digits 0..i-1 all equal 0.
  - A digit equal to 0 that decrements becomes MODULUS-1.
- Latency: one clock from en/load to the updated count.
- tc (combinational):
  - tc = en & (up_dn ? all digits == MODULUS-1 : all digits == 0).
  - It asserts in the cycle where the next edge would wrap; cascade tc into the en of a downstream counter.
- SATURATE=0:
  - At all-max going up, the next count is all 0.
  - At all-0 going down, the next count is all max.
  - wrap = 1 on the cycle after that edge, for exactly one cycle.
- SATURATE=1:
  - When tc=1 (and load=0), count holds.
  - wrap stays 0 permanently.
  - tc still asserts normally.
- Direction change takes effect on the same edge, with no extra state.
- en=0 holds count; wrap <= 0.
- Out-of-range digits can only occur via X; behaviour is undefined and is not checked.

Decomposition:
- Shared package, modn_pkg:
  - function clog2_min1, returning at least 1 bit.
  - Constants for the default MODULUS and DIGITS.
- Sub-module modn_digit, one per digit via a generate loop:
  - Inputs: clk, reset_n, load, load_digit, step (carry-in & en), up_dn.
  - Outputs: digit, at_max, at_min.
- The top level builds the prefix AND chains of at_max/at_min to form each digit's step, tc, and the saturate gating.

Test Plan (DIGITS=2, MODULUS=10 unless stated):
- Reset / async reset: reset_n low, then release; en=1, up_dn=1 for 5 clocks → count=0x05. Assert reset_n between edges → count=0 immediately, wrap=0.
- Up carry and wrap: load 0x98, en=1, up_dn=1 → 0x99 with tc=1, then next edge 0x00 with wrap=1 for one cycle only. Then 0x01 with wrap=0.
- Down borrow: load 0x10, up_dn=0 → 0x09. Load 0x00 → tc=1, next edge 0x99, wrap=1.
- Load priority and clamping: load=1, en=1, load_val=0xC3 → count=0x93 (digit 1 clamped to 9); no increment on that edge.
- Saturate (SATURATE=1): load 0x98, count up 3 clocks → 0x99, 0x99, 0x99; tc=1, wrap never asserts. Flip up_dn=0 → 0x98 on the next edge.
- Non-decimal generality: MODULUS=6, DIGITS=3, count up from 0 for 216 clocks → returns to 0 with a single wrap pulse. tc high exactly once per 216 cycles.
